// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller (master) and its datapath (slave).
// The datapath side supplies opcode, Zero and mem_ready. The controller drives every control strobe back.
interface multicycle_ctrl_if #(
  parameter int COUNT_W = 16
);
  logic [5:0]         opcode;
  logic               Zero;
  logic               mem_ready;
  logic               PCEn;
  logic [1:0]         PCSource;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic               illegal;
  logic [3:0]         state_dbg;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    input  opcode, Zero, mem_ready,
    output PCEn, PCSource, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal, state_dbg,
           instr_count
  );

  modport slave (
    output opcode, Zero, mem_ready,
    input  PCEn, PCSource, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal, state_dbg,
           instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main control FSM: Moore-decoded datapath strobes, and a PC enable that is combinational in Zero.
// Each instruction takes 2-5 cycles. The FSM stalls in FETCH, MEMRD and MEMWR until mem_ready is high.
module multicycle_ctrl #(
  parameter int COUNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXE   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXE   = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t             state_q, state_d;
  logic [5:0]         op_q, op_d;
  logic               illegal_q, illegal_d;
  logic [COUNT_W-1:0] cnt_q;

  logic       pc_write, pc_write_cond;
  logic [1:0] pc_source;
  logic       iord, mem_read, mem_write, ir_write;
  logic       memto_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       ne;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      if (state_q == S_FETCH && bus.mem_ready)
        cnt_q <= cnt_q + COUNT_W'(1);
    end
  end

  always_comb begin
    state_d       = S_FETCH;
    op_d          = op_q;
    illegal_d     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    memto_reg     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        state_d   = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is dispatched.
        alu_src_b = 2'b11;
        op_d      = bus.opcode;
        case (bus.opcode)
          OP_RTYPE:      state_d = S_REXE;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI:       state_d = S_IEXE;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        memto_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_REXE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // bne inverts the sense of Zero; op_q still holds the opcode latched in DECODE.
  assign ne = (op_q == OP_BNE);

  assign bus.PCEn        = pc_write | (pc_write_cond & (bus.Zero ^ ne));
  assign bus.PCSource    = pc_source;
  assign bus.IorD        = iord;
  assign bus.MemRead     = mem_read;
  assign bus.MemWrite    = mem_write;
  assign bus.IRWrite     = ir_write;
  assign bus.MemtoReg    = memto_reg;
  assign bus.RegDst      = reg_dst;
  assign bus.RegWrite    = reg_write;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ALUOp       = alu_op;
  assign bus.illegal     = illegal_q;
  assign bus.state_dbg   = state_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM of the multicycle MIPS datapath, directly upstream of the PC source selector.
- Drives PCSource and the PC write enable, plus every other datapath control line: memory, IR, register file and ALU muxes.
- Sequences each instruction through fetch/decode/execute states.
- Stalls on a memory ready handshake.

Parameters:
COUNT_W, 16, width of the retired-fetch counter instr_count

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
PCEn  out  1  PC register load enable
PCSource  out  2  selector code: 00 sequential/ALU, 01 branch target, 10 jump target
IorD  out  1  memory address: 0 PC, 1 ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR load
MemtoReg  out  1  writeback data: 0 ALUOut, 1 MDR
RegDst  out  1  dest register: 0 rt, 1 rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0 PC, 1 reg A
ALUSrcB  out  2  00 reg B, 01 const 4, 10 sext imm, 11 sext imm<<2
ALUOp  out  2  00 add, 01 sub, 10 funct field
illegal  out  1  one-cycle pulse on undefined opcode
state_dbg  out  4  current state encoding
instr_count  out  COUNT_W  completed fetches, wraps

Behaviour:
- Clock and reset:
  - Single clock, asynchronous active-low reset (rst_n), as decided.
  - Reset forces state=FETCH, op_q=0, illegal=0, instr_count=0.
- Output style:
  - All control outputs except illegal and instr_count are Moore-decoded from state.
  - FETCH additionally gates PCWrite/IRWrite with mem_ready.
  - Any output not listed for a state is 0.
- Reset output values: state FETCH with mem_ready=0 gives MemRead=1, ALUSrcB=01, all other outputs 0.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5.
  - REXE=6, RWB=7, BRANCH=8, JUMP=9, IEXE=10, IWB=11.
  - Codes 12-15 are unreachable; if entered, next state is FETCH with all outputs 0.
- Per-state outputs:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target). op_q<=opcode.
  - DECODE dispatch:
    - 000000 -> REXE
    - 100011 / 101011 -> MEMADR
    - 000100 / 000101 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> IEXE
    - other -> FETCH, with illegal=1 in the following cycle.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD if op_q=lw, else MEMWR.
  - MEMRD: MemRead=1, IorD=1. Holds until mem_ready=1, then goes to MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
  - MEMWR: MemWrite=1, IorD=1. Holds MemWrite until mem_ready=1, then goes to FETCH.
  - REXE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RWB.
  - RWB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
  - IEXE: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to IWB.
  - IWB: RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1. Goes to FETCH.
  - JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- PC enable:
  - PCEn = PCWrite | (PCWriteCond & (Zero ^ ne)), where ne = (op_q==000101).
  - PCEn is combinational in Zero, evaluated in the same cycle.
- Latency: R-type/addi 4 cycles, lw 5, sw 4, beq/bne 3, j 3, illegal 2; each with mem_ready=1 at every wait.
- instr_count:
  - Increments on the clock edge where state=FETCH and mem_ready=1.
  - Wraps from 2^COUNT_W-1 to 0.
- illegal: registered; high exactly one cycle, coincident with the first cycle of the return to FETCH.
- Reset mid-instruction: returns to FETCH immediately, with no write strobe active after rst_n falls.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

Test Plan:
- Reset: hold rst_n=0 with clk toggling -> state_dbg=0, MemRead=1, PCEn=0, instr_count=0. Release with mem_ready=1 -> PCEn=1 and PCSource=00 in the first cycle.
- R-type (opcode 000000), mem_ready=1 -> states 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7. instr_count=1 after the FETCH edge.
- lw (100011) with mem_ready=0 for 3 cycles in MEMRD -> MEMRD held 4 cycles with MemRead=1, IorD=1. Then MEMWB with MemtoReg=1, RegWrite=1.
- Branches, PCSource=01 throughout:
  - beq (000100) with Zero=1 -> PCEn=1.
  - beq with Zero=0 -> PCEn=0.
  - bne (000101) with Zero=0 -> PCEn=1.
- j (000010) -> JUMP state with PCSource=10, PCEn=1, back to FETCH next cycle. Opcode 111111 -> DECODE then FETCH, illegal=1 for exactly one cycle, no RegWrite/MemWrite.
- sw stalled in MEMWR with mem_ready=0, rst_n pulsed low -> MemWrite drops immediately, state_dbg=0. With COUNT_W=2, 5 fetches -> instr_count=1.
